// File: rtl/vram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_port_arbiter
// Description : Shares the single VRAM read port between display scanout and
//               CPU reads (display first, CPU guaranteed a slot after a
//               bounded number of display wins) and forwards CPU writes
//               straight to the memory write port.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_port_arbiter #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 8,
  parameter int CPU_WAIT_MAX  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  // display fetch
  input  logic                     disp_req,
  input  logic [ADDRESS_WIDTH-1:0] disp_addr,
  output logic                     disp_ack,
  output logic [DATA_WIDTH-1:0]    disp_data,
  output logic                     disp_valid,
  // CPU read
  input  logic                     cpu_rd_req,
  input  logic [ADDRESS_WIDTH-1:0] cpu_rd_addr,
  output logic                     cpu_rd_ack,
  output logic [DATA_WIDTH-1:0]    cpu_rd_data,
  output logic                     cpu_rd_valid,
  // CPU write
  input  logic                     cpu_wr_req,
  input  logic [ADDRESS_WIDTH-1:0] cpu_wr_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wr_data,
  output logic                     cpu_wr_ack,
  // memory
  output logic [ADDRESS_WIDTH-1:0] mem_read_addr,
  output logic                     mem_read_enable,
  input  logic [DATA_WIDTH-1:0]    mem_read_data,
  output logic [ADDRESS_WIDTH-1:0] mem_write_addr,
  output logic                     mem_write_enable,
  output logic [DATA_WIDTH-1:0]    mem_write_data
);

  localparam logic [3:0] c_WAIT_MAX = 4'(CPU_WAIT_MAX);

  logic [3:0] r_wait_cnt;
  logic       r_disp_owner;
  logic       r_cpu_owner;

  logic w_force_cpu;
  logic w_grant_disp;
  logic w_grant_cpu;

  // Arbitration: display wins unless the CPU has waited its full budget
  always_comb begin
    w_force_cpu  = cpu_rd_req && (r_wait_cnt == c_WAIT_MAX);
    w_grant_disp = 1'b0;
    w_grant_cpu  = 1'b0;
    if (!reset) begin
      if (disp_req && cpu_rd_req && w_force_cpu) begin
        w_grant_cpu = 1'b1;
      end else if (disp_req) begin
        w_grant_disp = 1'b1;
      end else if (cpu_rd_req) begin
        w_grant_cpu = 1'b1;
      end
    end
  end

  assign disp_ack        = w_grant_disp;
  assign cpu_rd_ack      = w_grant_cpu;
  assign mem_read_enable = w_grant_disp | w_grant_cpu;
  assign mem_read_addr   = w_grant_cpu ? cpu_rd_addr : disp_addr;

  // Owner register tracks which requester the in-flight read belongs to
  always_ff @(posedge clk) begin
    if (reset) begin
      r_disp_owner <= 1'b0;
      r_cpu_owner  <= 1'b0;
    end else begin
      r_disp_owner <= w_grant_disp;
      r_cpu_owner  <= w_grant_cpu;
    end
  end

  // Starvation counter: counts display wins while a CPU read is pending
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= 4'd0;
    end else if (!cpu_rd_req || w_grant_cpu) begin
      r_wait_cnt <= 4'd0;
    end else if (w_grant_disp && (r_wait_cnt != c_WAIT_MAX)) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  // Valids are masked by reset so a grant issued just before reset rises
  // never surfaces as a pulse; data is a straight copy of the memory output
  assign disp_valid   = r_disp_owner & ~reset;
  assign cpu_rd_valid = r_cpu_owner & ~reset;
  assign disp_data    = mem_read_data;
  assign cpu_rd_data  = mem_read_data;

  // Writes bypass arbitration entirely
  assign cpu_wr_ack       = cpu_wr_req & ~reset;
  assign mem_write_enable = cpu_wr_ack;
  assign mem_write_addr   = cpu_wr_addr;
  assign mem_write_data   = cpu_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_vram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_port_arbiter
// Description : Directed self-checking bench for vram_port_arbiter with a
//               behavioural read-before-write memory attached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_ack;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          cpu_rd_req;
  logic [AW-1:0] cpu_rd_addr;
  logic          cpu_rd_ack;
  logic [DW-1:0] cpu_rd_data;
  logic          cpu_rd_valid;
  logic          cpu_wr_req;
  logic [AW-1:0] cpu_wr_addr;
  logic [DW-1:0] cpu_wr_data;
  logic          cpu_wr_ack;
  logic [AW-1:0] mem_read_addr;
  logic          mem_read_enable;
  logic [DW-1:0] mem_read_data;
  logic [AW-1:0] mem_write_addr;
  logic          mem_write_enable;
  logic [DW-1:0] mem_write_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vram_port_arbiter #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .CPU_WAIT_MAX (4)
  ) u_dut (
    .clk             (clk),
    .reset           (reset),
    .disp_req        (disp_req),
    .disp_addr       (disp_addr),
    .disp_ack        (disp_ack),
    .disp_data       (disp_data),
    .disp_valid      (disp_valid),
    .cpu_rd_req      (cpu_rd_req),
    .cpu_rd_addr     (cpu_rd_addr),
    .cpu_rd_ack      (cpu_rd_ack),
    .cpu_rd_data     (cpu_rd_data),
    .cpu_rd_valid    (cpu_rd_valid),
    .cpu_wr_req      (cpu_wr_req),
    .cpu_wr_addr     (cpu_wr_addr),
    .cpu_wr_data     (cpu_wr_data),
    .cpu_wr_ack      (cpu_wr_ack),
    .mem_read_addr   (mem_read_addr),
    .mem_read_enable (mem_read_enable),
    .mem_read_data   (mem_read_data),
    .mem_write_addr  (mem_write_addr),
    .mem_write_enable(mem_write_enable),
    .mem_write_data  (mem_write_data)
  );

  // Behavioural VRAM: registered read, read-before-write on the same edge
  logic [DW-1:0] r_mem [1024];
  always @(posedge clk) begin
    if (mem_read_enable) mem_read_data <= r_mem[mem_read_addr];
    if (mem_write_enable) r_mem[mem_write_addr] <= mem_write_data;
  end

  // Preload pattern: mem[i] = i ^ 0x5A, except mem[0x010] = 0xA5
  function automatic logic [DW-1:0] preload(input int a);
    logic [DW-1:0] v;
    v = DW'(a) ^ 8'h5A;
    if (a == 16) v = 8'hA5;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic prev_cpu;
    bit   exp_cpu;

    for (int i = 0; i < 1024; i++) r_mem[i] = preload(i);

    // ---------------- reset with everything requesting ----------------
    reset       = 1'b1;
    disp_req    = 1'b1;
    disp_addr   = 10'h005;
    cpu_rd_req  = 1'b1;
    cpu_rd_addr = 10'h010;
    cpu_wr_req  = 1'b1;
    cpu_wr_addr = 10'h3FF;
    cpu_wr_data = 8'h00;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_disp_ack", disp_ack, 0);
      chk("rst_cpu_ack", cpu_rd_ack, 0);
      chk("rst_rd_en", mem_read_enable, 0);
      chk("rst_wr_ack", cpu_wr_ack, 0);
      chk("rst_wr_en", mem_write_enable, 0);
      chk("rst_disp_valid", disp_valid, 0);
      chk("rst_cpu_valid", cpu_rd_valid, 0);
    end
    reset      = 1'b0;
    cpu_wr_req = 1'b0;

    // ---------------- contention: D,D,D,D,C,D,D,D,D,C ----------------
    prev_cpu = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      exp_cpu = (k % 5 == 4);
      chk("arb_disp_ack", disp_ack, !exp_cpu);
      chk("arb_cpu_ack", cpu_rd_ack, exp_cpu);
      chk("arb_rd_addr", mem_read_addr, exp_cpu ? 32'h010 : 32'h005);
      if (k > 0) begin
        chk("arb_disp_valid", disp_valid, !prev_cpu);
        chk("arb_cpu_valid", cpu_rd_valid, prev_cpu);
        chk("arb_data", prev_cpu ? cpu_rd_data : disp_data, prev_cpu ? 8'hA5 : 8'h5F);
      end
      prev_cpu = exp_cpu;
      step();
    end
    disp_req   = 1'b0;
    cpu_rd_req = 1'b0;
    #1;
    chk("arb_last_cpu_valid", cpu_rd_valid, 1);
    chk("arb_last_disp_valid", disp_valid, 0);
    chk("arb_last_data", cpu_rd_data, 8'hA5);
    step();

    // ---------------- lone CPU read of 0x010 ----------------
    cpu_rd_req  = 1'b1;
    cpu_rd_addr = 10'h010;
    #1;
    chk("cpu_ack", cpu_rd_ack, 1);
    chk("cpu_rd_addr", mem_read_addr, 10'h010);
    step();
    cpu_rd_req = 1'b0;
    #1;
    chk("cpu_valid", cpu_rd_valid, 1);
    chk("cpu_data", cpu_rd_data, 8'hA5);
    chk("cpu_disp_valid", disp_valid, 0);
    step();
    chk("cpu_valid_pulse", cpu_rd_valid, 0);

    // ---------------- display streaming 0x000..0x0FF ----------------
    disp_req = 1'b1;
    for (int i = 0; i < 256; i++) begin
      disp_addr = AW'(i);
      #1;
      chk("strm_ack", disp_ack, 1);
      if (i > 0) begin
        chk("strm_valid", disp_valid, 1);
        chk("strm_data", disp_data, preload(i - 1));
      end
      step();
    end
    disp_req = 1'b0;
    #1;
    chk("strm_last_valid", disp_valid, 1);
    chk("strm_last_data", disp_data, preload(255));
    step();

    // ---------------- same-address read and write ----------------
    disp_req    = 1'b1;
    disp_addr   = 10'h020;
    cpu_wr_req  = 1'b1;
    cpu_wr_addr = 10'h020;
    cpu_wr_data = 8'h3C;
    #1;
    chk("rw_wr_ack", cpu_wr_ack, 1);
    chk("rw_wr_en", mem_write_enable, 1);
    chk("rw_wr_addr", mem_write_addr, 10'h020);
    chk("rw_wr_data", mem_write_data, 8'h3C);
    chk("rw_disp_ack", disp_ack, 1);
    step();
    cpu_wr_req = 1'b0;
    #1;
    chk("rw_old_valid", disp_valid, 1);
    chk("rw_old_data", disp_data, 8'h7A);
    chk("rw_wr_ack_off", cpu_wr_ack, 0);
    step();
    disp_req = 1'b0;
    #1;
    chk("rw_new_data", disp_data, 8'h3C);
    step();

    // ---------------- reset right after a CPU grant ----------------
    cpu_rd_req  = 1'b1;
    cpu_rd_addr = 10'h010;
    #1;
    chk("mid_cpu_ack", cpu_rd_ack, 1);
    step();
    cpu_rd_req = 1'b0;
    reset      = 1'b1;
    #1;
    chk("mid_cpu_valid", cpu_rd_valid, 0);
    step();
    reset = 1'b0;
    step();
    chk("mid_cpu_valid_after", cpu_rd_valid, 0);

    // ---------------- reset clears a partially built wait count ------
    disp_req    = 1'b1;
    disp_addr   = 10'h005;
    cpu_rd_req  = 1'b1;
    cpu_rd_addr = 10'h010;
    step();
    step();
    #1;
    chk("cnt_third_disp", disp_ack, 1);
    step();
    reset = 1'b1;
    #1;
    chk("cnt_rst_disp_valid", disp_valid, 0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("cnt_disp_ack", disp_ack, (k != 4));
      chk("cnt_cpu_ack", cpu_rd_ack, (k == 4));
      step();
    end
    disp_req   = 1'b0;
    cpu_rd_req = 1'b0;
    #1;
    chk("cnt_cpu_valid", cpu_rd_valid, 1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
